// File: rtl/io_pkg.sv
// Shared definitions for the IO-bus input conditioning blocks.
package io_pkg;

    // Default width of the switch field on the IO bus.
    localparam int SWITCH_W = 4;

    // Debouncer FSM: STABLE tracks the committed value, SETTLE qualifies a candidate.
    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } debounce_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. Each bit is
// synchronized on its own; there is no logic between the two stages.
module sync_2ff #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces raw board switches into a clean vector and reports each committed
// change as accumulated rise/fall masks behind a valid/ack handshake.
module switch_debouncer
    import io_pkg::*;
#(
    parameter int               WIDTH         = SWITCH_W,
    parameter int               STABLE_CYCLES = 1_000_000,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_out,
    output logic             event_valid,
    output logic [WIDTH-1:0] event_rise,
    output logic [WIDTH-1:0] event_fall,
    output logic             event_overrun,
    input  logic             event_ack
);

    // A commit happens when the counter reads STABLE_CYCLES-1, so it only
    // needs to hold values 0..STABLE_CYCLES-1 and never wraps.
    localparam int             CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] counter;
    debounce_state_t  state;

    logic             commit;
    logic             ack_take;
    logic [WIDTH-1:0] rise_new;
    logic [WIDTH-1:0] fall_new;

    sync_2ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (switch_raw),
        .q   (sync)
    );

    // Same priority as the FSM below: bounce-back wins, then candidate change, then count.
    assign commit   = (state == SETTLE) && (sync != switch_out) &&
                      (sync == candidate) && (counter == CNT_MAX);
    assign ack_take = event_valid && event_ack;
    assign rise_new = candidate & ~switch_out;
    assign fall_new = ~candidate & switch_out;

    // Qualify a new synchronized value for STABLE_CYCLES cycles before committing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= STABLE;
            candidate  <= RESET_VALUE;
            counter    <= '0;
            switch_out <= RESET_VALUE;
        end else begin
            case (state)
                STABLE: begin
                    if (sync != switch_out) begin
                        candidate <= sync;
                        counter   <= '0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync == switch_out) begin
                        // Input bounced back to the committed value: drop the candidate.
                        counter <= '0;
                        state   <= STABLE;
                    end else if (sync != candidate) begin
                        // Different new value: restart qualification on it.
                        candidate <= sync;
                        counter   <= '0;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + CNT_W'(1);
                    end else begin
                        switch_out <= candidate;
                        state      <= STABLE;
                    end
                end
                default: state <= STABLE;
            endcase
        end
    end

    // Event masks: OR-accumulate commits until acked; a same-edge ack keeps only the new commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_valid   <= 1'b0;
            event_rise    <= '0;
            event_fall    <= '0;
            event_overrun <= 1'b0;
        end else if (commit) begin
            event_valid <= 1'b1;
            if (ack_take) begin
                event_rise    <= rise_new;
                event_fall    <= fall_new;
                event_overrun <= 1'b0;
            end else begin
                event_rise    <= event_rise | rise_new;
                event_fall    <= event_fall | fall_new;
                event_overrun <= event_overrun | event_valid;
            end
        end else if (ack_take) begin
            event_valid   <= 1'b0;
            event_rise    <= '0;
            event_fall    <= '0;
            event_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4, WIDTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// A value placed on switch_raw just after an edge is first sampled at the next
// edge (tick 1) and must appear on switch_out after tick 7 (k+STABLE_CYCLES+2).
module tb_switch_debouncer;

    localparam int W  = 4;
    localparam int SC = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] switch_raw;
    logic [W-1:0] switch_out;
    logic         event_valid;
    logic [W-1:0] event_rise;
    logic [W-1:0] event_fall;
    logic         event_overrun;
    logic         event_ack;

    int n_assert = 0;
    int n_fail   = 0;

    switch_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC),
        .RESET_VALUE   (4'b0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .switch_raw    (switch_raw),
        .switch_out    (switch_out),
        .event_valid   (event_valid),
        .event_rise    (event_rise),
        .event_fall    (event_fall),
        .event_overrun (event_overrun),
        .event_ack     (event_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full observable state in one call.
    task automatic chk_all(input string tag, input logic [3:0] out, input logic vld,
                           input logic [3:0] rise, input logic [3:0] fall, input logic ovr);
        chk({tag, ".out"},  32'(switch_out),    32'(out));
        chk({tag, ".vld"},  32'(event_valid),   32'(vld));
        chk({tag, ".rise"}, 32'(event_rise),    32'(rise));
        chk({tag, ".fall"}, 32'(event_fall),    32'(fall));
        chk({tag, ".ovr"},  32'(event_overrun), 32'(ovr));
    endtask

    task automatic ack_pulse();
        event_ack = 1'b1;
        tick(1);
        event_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        switch_raw = 4'hF;
        event_ack  = 1'b0;

        // 1. Reset with all switches high.
        tick(3);
        chk_all("rst_hold", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("rst_rel", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        tick(6);
        chk("rst_t6.out", 32'(switch_out), 32'h0);
        chk("rst_t6.vld", 32'(event_valid), 32'h0);
        tick(1);
        chk_all("rst_t7", 4'hF, 1'b1, 4'hF, 4'h0, 1'b0);
        ack_pulse();
        chk_all("rst_ack", 4'hF, 1'b0, 4'h0, 4'h0, 1'b0);
        // Ack while nothing pending is ignored.
        ack_pulse();
        chk_all("idle_ack", 4'hF, 1'b0, 4'h0, 4'h0, 1'b0);

        // Return to 0 so the clean step starts from 0.
        switch_raw = 4'h0;
        tick(7);
        chk_all("to0", 4'h0, 1'b1, 4'h0, 4'hF, 1'b0);
        ack_pulse();

        // 2. Clean step 0 -> 5.
        switch_raw = 4'h5;
        tick(6);
        chk("step_t6.out", 32'(switch_out), 32'h0);
        tick(1);
        chk_all("step_t7", 4'h5, 1'b1, 4'h5, 4'h0, 1'b0);
        ack_pulse();
        chk_all("step_ack", 4'h5, 1'b0, 4'h0, 4'h0, 1'b0);

        switch_raw = 4'h0;
        tick(7);
        ack_pulse();
        chk_all("back0", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        // 3. Bounce on bit0: 2 cycles high, 2 low, for 20 cycles, then hold high.
        for (int i = 0; i < 5; i++) begin
            switch_raw = 4'h1;
            tick(2);
            chk("bnc_hi.out", 32'(switch_out), 32'h0);
            switch_raw = 4'h0;
            tick(2);
            chk("bnc_lo.out", 32'(switch_out), 32'h0);
            chk("bnc_lo.vld", 32'(event_valid), 32'h0);
        end
        switch_raw = 4'h1;
        tick(6);
        chk("bnc_t6.out", 32'(switch_out), 32'h0);
        tick(1);
        chk_all("bnc_t7", 4'h1, 1'b1, 4'h1, 4'h0, 1'b0);
        tick(5);
        chk_all("bnc_once", 4'h1, 1'b1, 4'h1, 4'h0, 1'b0);
        ack_pulse();

        switch_raw = 4'h0;
        tick(7);
        ack_pulse();
        chk_all("pre_glitch", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        // 4. Single-cycle glitch must not commit.
        switch_raw = 4'h8;
        tick(1);
        switch_raw = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("glitch.out", 32'(switch_out), 32'h0);
            chk("glitch.vld", 32'(event_valid), 32'h0);
        end

        // 5. Two commits without ack accumulate and flag overrun.
        switch_raw = 4'h3;
        tick(7);
        chk_all("ovr_c1", 4'h3, 1'b1, 4'h3, 4'h0, 1'b0);
        switch_raw = 4'h1;
        tick(7);
        chk_all("ovr_c2", 4'h1, 1'b1, 4'h3, 4'h2, 1'b1);
        ack_pulse();
        chk_all("ovr_ack", 4'h1, 1'b0, 4'h0, 4'h0, 1'b0);

        // 6. Build a pending event with overrun, then ack exactly on the 1 -> 9 commit edge.
        switch_raw = 4'h0;
        tick(7);
        switch_raw = 4'h1;
        tick(7);
        chk_all("coin_pre", 4'h1, 1'b1, 4'h1, 4'h1, 1'b1);
        switch_raw = 4'h9;
        tick(6);
        chk("coin_t6.out", 32'(switch_out), 32'h1);
        ack_pulse();
        chk_all("coin", 4'h9, 1'b1, 4'h8, 4'h0, 1'b0);
        ack_pulse();

        switch_raw = 4'h0;
        tick(7);
        ack_pulse();
        chk_all("pre_rst", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        // 7. Reset in the middle of qualifying 0 -> 6.
        switch_raw = 4'h6;
        tick(4);
        rst = 1'b0;
        #1;
        chk_all("mid_rst", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(6);
        chk_all("mid_t6", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        tick(1);
        chk_all("mid_t7", 4'h6, 1'b1, 4'h6, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
